// File: rtl/api_ext_port_master.sv
// ---------------------------------------------------------------------------
// api_ext_port_master
//
// Upstream driver for the api_extension I/O port. A single-cycle host access
// (host_cs / host_we / host_address / host_write_data) is turned into the
// port's multi-cycle command/status handshake. The result is returned to the
// host as a one-cycle host_ready pulse with host_error and host_read_data.
// A hung endpoint is aborted after TIMEOUT_CYCLES. The command is held IDLE
// for RELEASE_CYCLES after every access before the next request is taken.
//
// Parameters
//   TIMEOUT_CYCLES  cycles from command issue to forced abort (4..65535)
//   RELEASE_CYCLES  cycles command stays IDLE after completion (2..7)
//
// Ports
//   clk              system clock
//   reset_n          synchronous active-low reset
//   host_cs          request strobe, only looked at in IDLE
//   host_we          1 = write, 0 = read
//   host_address     target address, [31:24] selects the module
//   host_write_data  write data
//   host_read_data   read result, held from host_ready until next accept
//   host_ready       one-cycle completion pulse
//   host_error       error flag, only non-zero together with host_ready
//   host_busy        high from acceptance until the FSM is back in IDLE
//   command          port command: 0 IDLE, 1 READ, 3 WRITE
//   status           port status: 0 BUSY, 1 READY, 3 ERROR (2 = undefined)
//   address          port address, stable while command is non-IDLE
//   write_data       port write data, stable while command is non-IDLE
//   read_data        port read data
//   debug_state      current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RELEASE)
//
// Handshake: a request is taken on a rising edge where host_cs = 1 and the
// FSM is in IDLE (host_busy = 0); requests while busy are dropped, never
// queued. Exactly one host_ready pulse follows every accepted request unless
// reset intervenes. On the port side the command is issued, the endpoint
// acknowledges by reporting BUSY, and completion is the first non-BUSY
// status after that.
// ---------------------------------------------------------------------------
module api_ext_port_master #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [2:0]  RELEASE_CYCLES = 3'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_cs,
  input  logic        host_we,
  input  logic [31:0] host_address,
  input  logic [31:0] host_write_data,
  output logic [31:0] host_read_data,
  output logic        host_ready,
  output logic        host_error,
  output logic        host_busy,
  output logic [1:0]  command,
  input  logic [1:0]  status,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic [1:0]  debug_state
);

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  localparam logic [1:0] ST_BUSY   = 2'd0;
  localparam logic [1:0] ST_READY  = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  // Registered port status; every decision is taken on this copy.
  logic [1:0]  status_r;

  logic [15:0] timeout_ctr;
  logic [15:0] timeout_ctr_d;
  logic [2:0]  release_ctr;
  logic [2:0]  release_ctr_d;
  logic        we_r;
  logic        we_d;
  logic        err_flag;
  logic        err_flag_d;

  logic [1:0]  command_d;
  logic [31:0] address_d;
  logic [31:0] write_data_d;
  logic [31:0] host_read_data_d;
  logic        host_ready_d;
  logic        host_error_d;
  logic        host_busy_d;

  logic        timeout_hit;
  logic        release_done;
  logic        port_done;
  logic [15:0] timeout_inc;

  assign timeout_hit  = (timeout_ctr == (TIMEOUT_CYCLES - 16'd1));
  assign release_done = (release_ctr == (RELEASE_CYCLES - 3'd1));
  assign port_done    = (status_r != ST_BUSY);
  // Saturating increment so a very long stall can never wrap back to zero.
  assign timeout_inc  = (timeout_ctr == 16'hffff) ? timeout_ctr
                                                  : timeout_ctr + 16'd1;

  assign debug_state = state_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (host_cs) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // READY right after issue is the endpoint's idle status, not a
        // completion; only BUSY proves the command was taken.
        if (timeout_hit)                 state_d = S_RELEASE;
        else if (status_r == ST_BUSY)    state_d = S_WAIT;
      end
      S_WAIT: begin
        if (timeout_hit || port_done)    state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (release_done)                state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next values (all registered below)
  // -------------------------------------------------------------------------
  always_comb begin
    command_d        = command;
    address_d        = address;
    write_data_d     = write_data;
    host_read_data_d = host_read_data;
    host_ready_d     = 1'b0;
    host_error_d     = 1'b0;
    host_busy_d      = host_busy;
    we_d             = we_r;
    err_flag_d       = err_flag;
    timeout_ctr_d    = timeout_ctr;
    release_ctr_d    = release_ctr;

    case (state_q)
      S_IDLE: begin
        if (host_cs) begin
          address_d     = host_address;
          write_data_d  = host_write_data;
          we_d          = host_we;
          command_d     = host_we ? CMD_WRITE : CMD_READ;
          host_busy_d   = 1'b1;
          err_flag_d    = 1'b0;
          timeout_ctr_d = 16'd0;
        end
      end

      S_ISSUE, S_WAIT: begin
        timeout_ctr_d = timeout_inc;
        if (timeout_hit) begin
          // Abort wins over a completion seen in the same cycle.
          command_d        = CMD_IDLE;
          err_flag_d       = 1'b1;
          host_read_data_d = 32'd0;
          release_ctr_d    = 3'd0;
        end else if ((state_q == S_WAIT) && port_done) begin
          host_read_data_d = we_r ? 32'd0 : read_data;
          // ERROR (3) and the undefined code (2) both have bit 1 set.
          err_flag_d       = status_r[1];
          command_d        = CMD_IDLE;
          release_ctr_d    = 3'd0;
        end
      end

      S_RELEASE: begin
        release_ctr_d = release_ctr + 3'd1;
        if (release_done) begin
          host_ready_d = 1'b1;
          host_error_d = err_flag;
          host_busy_d  = 1'b0;
        end
      end

      default: begin
        command_d = CMD_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath / output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status_r       <= ST_READY;
      timeout_ctr    <= 16'd0;
      release_ctr    <= 3'd0;
      we_r           <= 1'b0;
      err_flag       <= 1'b0;
      command        <= CMD_IDLE;
      address        <= 32'd0;
      write_data     <= 32'd0;
      host_read_data <= 32'd0;
      host_ready     <= 1'b0;
      host_error     <= 1'b0;
      host_busy      <= 1'b0;
    end else begin
      status_r       <= status;
      timeout_ctr    <= timeout_ctr_d;
      release_ctr    <= release_ctr_d;
      we_r           <= we_d;
      err_flag       <= err_flag_d;
      command        <= command_d;
      address        <= address_d;
      write_data     <= write_data_d;
      host_read_data <= host_read_data_d;
      host_ready     <= host_ready_d;
      host_error     <= host_error_d;
      host_busy      <= host_busy_d;
    end
  end

endmodule

// File: tb/tb_api_ext_port_master.sv
// ---------------------------------------------------------------------------
// tb_api_ext_port_master
//
// Directed bench for api_ext_port_master with a small behavioural model of
// the api_extension endpoint. Expected host results ({error, data}) are
// queued when a request is driven and compared when host_ready pulses.
// ---------------------------------------------------------------------------
module tb_api_ext_port_master;

  localparam logic [15:0] TB_TIMEOUT = 16'd16;
  localparam logic [2:0]  TB_RELEASE = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        host_cs = 1'b0;
  logic        host_we = 1'b0;
  logic [31:0] host_address = 32'd0;
  logic [31:0] host_write_data = 32'd0;
  logic [31:0] host_read_data;
  logic        host_ready;
  logic        host_error;
  logic        host_busy;
  logic [1:0]  command;
  logic [1:0]  status;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [1:0]  debug_state;

  api_ext_port_master #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .RELEASE_CYCLES (TB_RELEASE)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .host_cs         (host_cs),
    .host_we         (host_we),
    .host_address    (host_address),
    .host_write_data (host_write_data),
    .host_read_data  (host_read_data),
    .host_ready      (host_ready),
    .host_error      (host_error),
    .host_busy       (host_busy),
    .command         (command),
    .status          (status),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data),
    .debug_state     (debug_state)
  );

  // ---------------- endpoint model ----------------
  // Idle: READY. On a command: READY for 2 more cycles, BUSY for 2, then
  // READY (or ERROR for a non-zero prefix) with data until command is IDLE.
  logic [1:0]  p_state = 2'd0;
  logic [1:0]  p_status = 2'd1;
  logic [31:0] p_rd = 32'd0;
  logic [1:0]  p_cmd = 2'd0;
  logic [31:0] p_addr = 32'd0;
  logic [31:0] p_wd = 32'd0;
  logic [1:0]  p_cnt = 2'd0;
  logic [31:0] r10 = 32'd0;
  logic [31:0] r11 = 32'd0;
  logic        stub_ready = 1'b0;

  assign status    = stub_ready ? 2'd1 : p_status;
  assign read_data = p_rd;

  function automatic logic [31:0] port_read(input logic [23:0] a);
    case (a)
      24'h000000: port_read = 32'h6170692d;
      24'h000001: port_read = 32'h65787420;
      24'h000010: port_read = r10;
      24'h000011: port_read = r11;
      24'h000012: port_read = r10 + r11;
      default:    port_read = 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    case (p_state)
      2'd0: begin
        p_status <= 2'd1;
        if (command != 2'd0) begin
          p_cmd   <= command;
          p_addr  <= address;
          p_wd    <= write_data;
          p_cnt   <= 2'd0;
          p_state <= 2'd1;
        end
      end
      2'd1: begin
        if (p_cnt == 2'd1) begin
          p_status <= 2'd0;
          p_cnt    <= 2'd0;
          p_state  <= 2'd2;
        end else p_cnt <= p_cnt + 2'd1;
      end
      2'd2: begin
        if (p_cnt == 2'd1) begin
          if (p_addr[31:24] != 8'h00) begin
            p_status <= 2'd3;
            p_rd     <= 32'd0;
          end else begin
            p_status <= 2'd1;
            if (p_cmd == 2'd3) begin
              if (p_addr[23:0] == 24'h10) r10 <= p_wd;
              if (p_addr[23:0] == 24'h11) r11 <= p_wd;
              p_rd <= 32'd0;
            end else p_rd <= port_read(p_addr[23:0]);
          end
          p_state <= 2'd3;
        end else p_cnt <= p_cnt + 2'd1;
      end
      default: begin
        if (command == 2'd0) begin
          p_status <= 2'd1;
          p_state  <= 2'd0;
        end
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int ready_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  prev_cmd = 2'd0;
  logic [31:0] prev_addr = 32'd0;
  logic [31:0] prev_wd = 32'd0;

  always @(negedge clk) begin
    logic [32:0] e;
    if (reset_n === 1'b1) begin
      if (host_ready === 1'b1) begin
        ready_count++;
        check("ready_has_expectation", 64'(exp_q.size() != 0), 64'd1);
        check("ready_cmd_idle", 64'(command), 64'd0);
        check("ready_busy_low", 64'(host_busy), 64'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ready_result", 64'({host_error, host_read_data}), 64'(e));
        end
      end else begin
        check("error_outside_ready", 64'(host_error), 64'd0);
      end
      if (command != 2'd0 && prev_cmd != 2'd0) begin
        check("cmd_stable", 64'(command), 64'(prev_cmd));
        check("addr_stable", 64'(address), 64'(prev_addr));
        check("wdata_stable", 64'(write_data), 64'(prev_wd));
      end
    end
    prev_cmd  = reset_n ? command : 2'd0;
    prev_addr = address;
    prev_wd   = write_data;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_data, input logic exp_err);
    host_cs         = 1'b1;
    host_we         = we;
    host_address    = a;
    host_write_data = wd;
    exp_q.push_back({exp_err, exp_data});
    @(posedge clk);
    @(negedge clk);
    host_cs = 1'b0;
  endtask

  // edges counts rising edges from the accepting edge (inclusive) to the
  // edge that raised host_ready.
  task automatic wait_ready(input string tag, output int edges);
    edges = 1;
    while (host_ready !== 1'b1 && edges < 64) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_ready_seen"}, 64'(host_ready), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int rc0;
    int guard;

    repeat (3) @(negedge clk);
    check("rst_command", 64'(command), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_host_read_data", 64'(host_read_data), 64'd0);
    check("rst_host_ready", 64'(host_ready), 64'd0);
    check("rst_host_error", 64'(host_error), 64'd0);
    check("rst_host_busy", 64'(host_busy), 64'd0);

    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Identification read
    start_req(1'b0, 32'h00000000, 32'd0, 32'h6170692d, 1'b0);
    check("rd0_busy", 64'(host_busy), 64'd1);
    check("rd0_cmd_read", 64'(command), 64'd1);
    wait_ready("rd0", lat);
    check("rd0_latency_lt16", 64'(lat < 16), 64'd1);

    // Write / write / read-back sum
    start_req(1'b1, 32'h00000010, 32'h00000005, 32'd0, 1'b0);
    check("wr10_cmd_write", 64'(command), 64'd3);
    check("wr10_wdata", 64'(write_data), 64'd5);
    wait_ready("wr10", lat);
    start_req(1'b1, 32'h00000011, 32'h00000003, 32'd0, 1'b0);
    wait_ready("wr11", lat);
    start_req(1'b0, 32'h00000012, 32'd0, 32'h00000008, 1'b0);
    check("rd12_addr", 64'(address), 64'h12);
    wait_ready("rd12", lat);

    // Unmapped prefix
    start_req(1'b0, 32'h55000000, 32'd0, 32'd0, 1'b1);
    wait_ready("rd55", lat);

    // Endpoint that never reports BUSY -> timeout
    repeat (2) @(negedge clk);
    stub_ready = 1'b1;
    start_req(1'b0, 32'h00000004, 32'd0, 32'd0, 1'b1);
    wait_ready("tmo", lat);
    check("tmo_latency", 64'(lat), 64'(int'(TB_TIMEOUT) + int'(TB_RELEASE) + 1));
    stub_ready = 1'b0;
    repeat (4) @(negedge clk);

    // Request while busy is dropped; request in the ready cycle is taken
    rc0 = ready_count;
    start_req(1'b0, 32'h00000000, 32'd0, 32'h6170692d, 1'b0);
    host_cs         = 1'b1;
    host_we         = 1'b1;
    host_address    = 32'hfe000000;
    host_write_data = 32'h0000dead;
    repeat (2) @(negedge clk);
    check("collide_addr_held", 64'(address), 64'd0);
    check("collide_cmd_held", 64'(command), 64'd1);
    host_cs = 1'b0;
    wait_ready("collide", lat);
    start_req(1'b0, 32'h00000001, 32'd0, 32'h65787420, 1'b0);
    check("ready_cycle_accept_cmd", 64'(command), 64'd1);
    check("ready_cycle_accept_addr", 64'(address), 64'd1);
    check("collide_single_ready", 64'(ready_count - rc0), 64'd1);
    wait_ready("rdy_accept", lat);
    repeat (30) @(negedge clk);
    check("collide_ready_total", 64'(ready_count - rc0), 64'd2);

    // Reset in the middle of WAIT
    start_req(1'b0, 32'h00000000, 32'd0, 32'h6170692d, 1'b0);
    guard = 0;
    while (debug_state !== 2'd2 && guard < 32) begin
      @(negedge clk);
      guard++;
    end
    check("reached_wait", 64'(debug_state), 64'd2);
    reset_n = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("midrst_command", 64'(command), 64'd0);
    check("midrst_busy", 64'(host_busy), 64'd0);
    check("midrst_ready", 64'(host_ready), 64'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    start_req(1'b0, 32'h00000001, 32'd0, 32'h65787420, 1'b0);
    wait_ready("post_rst_rd1", lat);

    repeat (20) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/api_ext_port_master.md
Name: api_ext_port_master

Overview:
- Upstream driver for the api_extension I/O port (command/status/address/write_data/read_data).
- Converts a simple host access (cs/we, address, write data), issued by the CPU-facing register bus in network_path_shared, into the port's multi-cycle command/status handshake.
- Returns read data plus a completion or error indication to the host.
- Guards against a hung endpoint with a timeout and enforces the release phase the port needs between transactions.

Parameters:
- TIMEOUT_CYCLES, 16'd1024: max cycles from command issue to completion before aborting with error; legal 4..65535.
- RELEASE_CYCLES, 3'd3: cycles command is held IDLE after completion before the next request is accepted; legal 2..7.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- host_cs  in  1  request strobe, sampled only in IDLE
- host_we  in  1  1 = write, 0 = read; qualified by host_cs
- host_address  in  32  target address; [31:24] is the module prefix
- host_write_data  in  32  write data
- host_read_data  out  32  read result, valid from the host_ready pulse until the next accepted request
- host_ready  out  1  one-cycle completion pulse
- host_error  out  1  valid with host_ready: port returned ERROR, or timeout
- host_busy  out  1  high from request acceptance until return to IDLE
- command  out  2  port command: 0 = IDLE, 1 = READ, 3 = WRITE
- status  in  2  port status: 0 = BUSY, 1 = READY, 3 = ERROR
- address  out  32  port address, held stable while command is non-IDLE
- write_data  out  32  port write data, held stable while command is non-IDLE
- read_data  in  32  port read data

Behaviour:
- Interface: one clock; reset is synchronous and active-low. All outputs are registered.
- Reset (reset_n low at a rising clk edge):
  - command = 0, address = 0, write_data = 0, host_read_data = 0.
  - host_ready = 0, host_error = 0, host_busy = 0.
  - FSM goes to IDLE; counters are cleared.
  - Reset mid-transaction abandons the access with no host_ready. The port sees command IDLE and finishes on its own.
- status is registered internally (status_r, 1 cycle) before use. read_data is sampled in the same cycle status_r is evaluated.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
  - IDLE:
    - host_cs = 1 at an edge: latch address, write_data and we; command <= (we ? 3 : 1); host_busy <= 1; clear timeout_ctr; go to ISSUE.
    - host_cs = 0: stay; host_ready = 0.
  - ISSUE: wait for status_r == BUSY, which confirms the port accepted the command. On BUSY go to WAIT. The port reports READY for several cycles after issue, so READY here is never treated as completion.
  - WAIT: on status_r != BUSY:
    - host_read_data <= (we ? 0 : read_data).
    - err_flag <= (status_r == ERROR). status_r == 2 (undefined) is also treated as error.
    - command <= 0; clear release_ctr; go to RELEASE.
  - Timeout (ISSUE or WAIT): timeout_ctr increments every cycle in these states. When timeout_ctr == TIMEOUT_CYCLES-1:
    - command <= 0; err_flag <= 1; host_read_data <= 0; go to RELEASE.
    - Timeout takes priority over completion in the same cycle.
  - RELEASE:
    - command stays 0; release_ctr increments each cycle.
    - When release_ctr == RELEASE_CYCLES-1: host_ready <= 1 for one cycle; host_error <= err_flag; host_busy <= 0; go to IDLE.
- host_cs while host_busy = 1 is ignored and never queued.
- host_cs in the same cycle host_ready is high: accepted, since the FSM is already in IDLE.
- host_error is meaningful only while host_ready = 1; it is driven 0 otherwise.
- address and write_data change only on acceptance in IDLE.
- Counters: timeout_ctr is 16 bits and saturates, never wrapping. release_ctr is 3 bits.
- Minimum access latency against api_extension, host_cs to host_ready, is under 16 cycles.

Test Plan:
- Read 0x00000000 against api_extension -> host_ready pulse, host_error = 0, host_read_data = 0x6170692d. Command returns to 0 before host_ready.
- Write 0x00000010 = 0x00000005, write 0x00000011 = 0x00000003, read 0x00000012 -> 0x00000008, no errors. address/write_data stable throughout each non-IDLE command.
- Read 0x55000000 (unmapped prefix) -> host_ready with host_error = 1.
- Stub port holding status = READY (never BUSY), TIMEOUT_CYCLES = 16 -> host_ready with host_error = 1, host_read_data = 0, exactly 16 + RELEASE_CYCLES + 1 cycles after acceptance.
- host_cs pulsed at 0xfe000000 while busy with another access -> second request ignored, exactly one host_ready. host_cs asserted during the host_ready cycle -> accepted.
- reset_n low mid-WAIT -> command, host_busy, host_ready all 0 next cycle. A subsequent read of 0x00000001 returns 0x65787420.
